// File: rtl/div_iter.sv
// Radix-2 restoring divider for EX, returns {remainder, quotient}.
// Optional macro: DIV_ZERO_FAST_EN (zero divisor short-cut).
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BYZERO,
    S_ON,
    S_END
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     shifted, diff;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic               go;

  assign go    = start_i & ~annul_i;
  assign a_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign b_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign a_mag = a_neg ? -opdata1_i : opdata1_i;
  assign b_mag = b_neg ? -opdata2_i : opdata2_i;

  // quo_q doubles as the dividend shift register
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign q_fix   = negq_q ? -quo_q : quo_q;
  assign r_fix   = negr_q ? -rem_q : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    ready_d  = ready_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          cnt_d  = '0;
          rem_d  = '0;
          quo_d  = a_mag;
          dvs_d  = b_mag;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
`ifdef DIV_ZERO_FAST_EN
          state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
`else
          state_d = S_ON;
`endif
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          state_d  = S_IDLE;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q == CW'(1)) begin
          state_d  = S_END;
          result_d = '0;
          ready_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d  = S_IDLE;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q == CW'(WIDTH)) begin
          state_d  = S_END;
          result_d = {r_fix, q_fix};
          ready_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      S_END: begin
        if (!start_i) begin
          state_d  = S_IDLE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = ((state_q == S_IDLE) & go)
                  | (state_q == S_ON)
                  | (state_q == S_BYZERO);

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: WIDTH=32 and WIDTH=8 instances, queue scoreboard.
module tb_div_iter;

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sd32 = 1'b0, st32 = 1'b0, an32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] res32;
  logic        rdy32, bsy32;

  logic        sd8 = 1'b0, st8 = 1'b0, an8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] res8;
  logic        rdy8, bsy8;

  div_iter #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .signed_div_i(sd32),
    .opdata1_i(a32), .opdata2_i(b32),
    .start_i(st32), .annul_i(an32),
    .result_o(res32), .ready_o(rdy32), .busy_o(bsy32)
  );

  div_iter #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .signed_div_i(sd8),
    .opdata1_i(a8), .opdata2_i(b8),
    .start_i(st8), .annul_i(an8),
    .result_o(res8), .ready_o(rdy8), .busy_o(bsy8)
  );

  bit          sel8 = 1'b0;
  logic        rdy_s, bsy_s;
  logic [63:0] res_s;
  assign rdy_s = sel8 ? rdy8 : rdy32;
  assign bsy_s = sel8 ? bsy8 : bsy32;
  assign res_s = sel8 ? {48'd0, res8} : res32;

  int          ntests = 0;
  int          nfail  = 0;
  logic [63:0] sb[$];

  task automatic chk(input string tag,
      input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    if (obs !== exp) begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit s,
      input logic [31:0] a_in, input logic [31:0] b_in, input int w);
    logic [31:0] m, a, b, ma, mb, q, r;
    bit na, nb;
    m  = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
    a  = a_in & m;
    b  = b_in & m;
    na = s & a[w-1];
    nb = s & b[w-1];
    ma = na ? ((~a + 32'd1) & m) : a;
    mb = nb ? ((~b + 32'd1) & m) : b;
    if (FAST && b == 32'd0) return 64'd0;
    if (mb == 32'd0) begin
      q = m;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (na ^ nb) q = (~q + 32'd1) & m;
    if (na) r = (~r + 32'd1) & m;
    return ({32'd0, r} << w) | {32'd0, q};
  endfunction

  task automatic issue(input bit w8, input bit s,
      input logic [31:0] a, input logic [31:0] b,
      input bit push, input logic [63:0] exp);
    @(negedge clk);
    sel8 = w8;
    if (w8) begin
      sd8 = s; a8 = a[7:0]; b8 = b[7:0]; st8 = 1'b1; an8 = 1'b0;
    end else begin
      sd32 = s; a32 = a; b32 = b; st32 = 1'b1; an32 = 1'b0;
    end
    if (push) sb.push_back(exp);
    #1;
    chk("busy_issue", bsy_s, 1'b1);
  endtask

  task automatic await_res(input int lat);
    int          e;
    bit          bok;
    logic [63:0] exp;
    e   = -1;
    bok = 1'b1;
    while (e < 100) begin
      @(posedge clk);
      e++;
      #1;
      if (rdy_s) break;
      if (bsy_s !== 1'b1) bok = 1'b0;
    end
    chk("latency", e, lat);
    chk("busy_run", bok, 1'b1);
    if (sb.size() > 0) exp = sb.pop_front();
    else exp = 64'hDEAD_DEAD_DEAD_DEAD;
    chk("result", res_s, exp);
    @(posedge clk);
    #1;
    chk("end_ready", rdy_s, 1'b1);
    chk("end_busy", bsy_s, 1'b0);
    chk("end_hold", res_s, exp);
    @(negedge clk);
    if (sel8) st8 = 1'b0;
    else st32 = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ready", rdy_s, 1'b0);
    chk("idle_result", res_s, 64'd0);
  endtask

  initial begin
    bit          w, s;
    logic [31:0] ra, rb;
    int          lat;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", res32, 64'd0);
    chk("rst_ready", rdy32, 1'b0);
    chk("rst_busy", bsy32, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    issue(0, 0, 32'd100, 32'd7, 1, 64'h00000002_0000000E);
    await_res(33);
    issue(0, 1, 32'hFFFFFFF9, 32'd2, 1, 64'hFFFFFFFF_FFFFFFFD);
    await_res(33);
    issue(0, 1, 32'd7, 32'hFFFFFFFE, 1, 64'h00000001_FFFFFFFD);
    await_res(33);
    issue(0, 1, 32'h80000000, 32'hFFFFFFFF, 1, 64'h00000000_80000000);
    await_res(33);
    issue(0, 0, 32'd7, 32'd0, 1,
          FAST ? 64'd0 : 64'h00000007_FFFFFFFF);
    await_res(FAST ? 2 : 33);

    issue(0, 0, 32'd12345, 32'd11, 0, 64'd0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    an32 = 1'b1;
    @(posedge clk);
    #1;
    chk("annul_ready", rdy32, 1'b0);
    chk("annul_busy", bsy32, 1'b0);
    chk("annul_result", res32, 64'd0);
    @(negedge clk);
    an32 = 1'b0;
    a32  = 32'd1000;
    b32  = 32'd10;
    sb.push_back(64'h00000000_00000064);
    #1;
    chk("restart_busy", bsy32, 1'b1);
    await_res(33);

    issue(0, 0, 32'd500, 32'd3, 0, 64'd0);
    repeat (5) @(posedge clk);
    #2;
    rst  = 1'b1;
    st32 = 1'b0;
    #1;
    chk("arst_result", res32, 64'd0);
    chk("arst_ready", rdy32, 1'b0);
    chk("arst_busy", bsy32, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    issue(0, 1, 32'd9, 32'd3, 1, 64'h00000000_00000003);
    await_res(33);

    issue(1, 0, 32'hFF, 32'h10, 1, 64'h0F0F);
    await_res(9);

    for (int i = 0; i < 24; i++) begin
      w  = (i % 3) != 0;
      s  = 1'($urandom_range(1));
      ra = $urandom;
      rb = $urandom;
      if (i % 7 == 3) rb = 32'd0;
      if (i % 5 == 1) rb = 32'hFFFFFFFF;
      if (w && (rb & 32'hFF) == 32'd0) rb = FAST ? 32'd0 : rb;
      lat = w ? 9 : 33;
      if (FAST && (rb & (w ? 32'hFF : 32'hFFFFFFFF)) == 32'd0)
        lat = 2;
      issue(w, s, ra, rb, 1, model(s, ra, rb, w ? 8 : 32));
      await_res(lat);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Parametrised iterative divider for the EX stage, executing DIV/DIVU over multiple cycles as a radix-2 restoring divider, one quotient bit per cycle. The EX stage issues operands with a start/annul handshake and stalls the pipeline on `busy_o`. The block returns `{remainder, quotient}` as one 2·WIDTH result, laid out as `{HI, LO}` so the EX stage forwards it through its existing hi/lo write path.

## Interface
- `WIDTH`, default 32: operand width; `result_o` is 2·WIDTH; iteration count equals WIDTH.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `signed_div_i`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i`  in  WIDTH  dividend.
- `opdata2_i`  in  WIDTH  divisor.
- `start_i`  in  1  request; held high by EX until result consumed.
- `annul_i`  in  1  cancel (flush/exception); highest priority after `rst`.
- `result_o`  out  2·WIDTH  `{remainder, quotient}`; registered.
- `ready_o`  out  1  `result_o` valid; registered.
- `busy_o`  out  1  stall request to pipeline; combinational from state and inputs.

## Operation
- States: IDLE, BYZERO, ON, END.
- Reset (any time, including mid-division):
  - state=IDLE, counter=0.
  - `result_o`=0, `ready_o`=0.
  - `busy_o`=0 unless start conditions hold.
- IDLE:
  - `start_i`=1 and `annul_i`=0 → latch operands, mode and sign info; clear counter.
  - Divisor zero with `DIV_ZERO_FAST_EN` defined → BYZERO; otherwise → ON.
  - Operands are captured only here; later input changes are ignored.
- Signed mode:
  - Operands converted to magnitudes at latch.
  - Quotient negated if operand signs differ.
  - Remainder takes the dividend's sign.
  - `-2^(WIDTH-1) / -1` → quotient `0x80..0`, remainder 0, no trap (wraps).
- ON:
  - Each edge: shift partial remainder left 1, trial subtract divisor magnitude (WIDTH+1 bits).
  - Non-negative difference → keep it, quotient bit=1; otherwise restore, bit=0.
  - Counter counts 0..WIDTH.
  - At counter==WIDTH: apply sign correction, load `result_o`, `ready_o`←1, → END.
  - `annul_i`=1 → IDLE next edge, `result_o`=0, `ready_o`=0.
- BYZERO: next edge `result_o`←0, `ready_o`←1, → END.
- END:
  - `ready_o`=1 and `result_o` held while `start_i`=1.
  - `start_i`=0 → IDLE, `ready_o`←0, `result_o`←0.
  - `annul_i` is ignored in END.
- `busy_o` = (IDLE & `start_i` & !`annul_i`) | ON | BYZERO.
  - `busy_o`=0 in END, so EX consumes the result and advances that cycle.

## Timing
- Start edge E0 (IDLE sampling `start_i`).
- Normal path: `ready_o` rises at E0+WIDTH+1 (33 edges for WIDTH=32).
- BYZERO path: `ready_o` rises at E0+2.
- Back-to-back: after END→IDLE, the next start is accepted the following edge, so there is at least one idle cycle between results.
- `busy_o` is asserted in the issue cycle, before E0, with no edge of latency.

## Configuration
- `DIV_ZERO_FAST_EN` defined:
  - Divisor 0 takes the BYZERO path: 2-edge latency, result all zeros.
- Not defined:
  - Divisor 0 runs the full ON sequence.
  - Unsigned result: quotient all ones, remainder = dividend.
  - Signed result: raw result from magnitudes, then sign-corrected per Operation.
  - Latency WIDTH+1.

## Test plan
- WIDTH=32, DIVU 100/7, `start_i` held → `ready_o` at E0+33, `result_o`={0x00000002, 0x0000000E}; `busy_o` high from issue cycle until END.
- DIV −7/2 → `result_o`={0xFFFFFFFF, 0xFFFFFFFD}; DIV 7/−2 → {0x00000001, 0xFFFFFFFD}; DIV 0x80000000/−1 → {0, 0x80000000}.
- DIVU 7/0:
  - With `DIV_ZERO_FAST_EN`: ready at E0+2, result 0.
  - Without: ready at E0+33, result {0x00000007, 0xFFFFFFFF}.
- Start DIVU, assert `annul_i` at E0+10 → IDLE at E0+11, `ready_o` never rises, `busy_o` low; a new start at E0+12 completes correctly.
- Assert `rst` asynchronously mid-ON → all outputs 0 immediately, state IDLE; release, issue DIV 9/3 → {0, 3}.
- WIDTH=8 build: DIVU 0xFF/0x10 → `result_o`={0x0F, 0x0F} at E0+9; randomised signed/unsigned operands checked against a reference model.
